// File: rtl/data_ram_pkg.sv
// Shared bus widths, FSM encoding and byte-lane constants for the data RAM.
// Lane numbering is big-endian: sel bit 3 covers data[31:24].
package data_ram_pkg;

   localparam int DATA_BUS_W      = 32;
   localparam int DATA_ADDR_BUS_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] SEL_NONE    = 4'b0000;
   localparam logic [3:0] SEL_WORD    = 4'b1111;
   localparam logic [3:0] SEL_HALF_HI = 4'b1100;
   localparam logic [3:0] SEL_HALF_LO = 4'b0011;

   function automatic logic is_misaligned(input logic [1:0] off, input logic [3:0] sel);
      logic half;
      half = (sel == SEL_HALF_HI) || (sel == SEL_HALF_LO);
      return ((sel == SEL_WORD) && (off != 2'b00)) || (half && off[0]);
   endfunction

   // Store data arrives right-justified from the CPU; spread it onto the selected lanes.
   function automatic logic [DATA_BUS_W-1:0] lane_data(input logic [3:0] sel,
                                                       input logic [DATA_BUS_W-1:0] data);
      case (sel)
         4'b1000, 4'b0100, 4'b0010, 4'b0001: return {4{data[7:0]}};
         SEL_HALF_HI, SEL_HALF_LO:           return {2{data[15:0]}};
         default:                            return data;
      endcase
   endfunction

   function automatic logic [DATA_BUS_W-1:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-wide storage with one byte-enabled write port and one combinational read port.
module data_ram_array
   import data_ram_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_BUS_W-1:0] wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_BUS_W-1:0] rdata
);

   logic [DATA_BUS_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram.sv
// Data RAM with IDLE/BUSY/RESP request FSM; optional wait states when
// DATA_RAM_WAIT_EN is defined (BUSY then lasts 1+WAIT_CYCLES cycles).
module data_ram
   import data_ram_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce_i,
   input  logic                       we_i,
   input  logic [DATA_ADDR_BUS_W-1:0] addr_i,
   input  logic [3:0]                 sel_i,
   input  logic [DATA_BUS_W-1:0]      data_i,
   output logic [DATA_BUS_W-1:0]      data_o,
   output logic                       ack_o,
   output logic                       err_o,
   output logic                       busy_o,
   output state_t                     dbg_state
);

   // Handshake: the CPU raises ce_i and holds it (request fields may change
   // freely, they are captured on acceptance) until ack_o pulses for one cycle;
   // busy_o is the stall, and dropping ce_i before ack_o cancels the request.
   state_t                state;
   logic                  we_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [1:0]            off_q;
   logic [3:0]            sel_q;
   logic [DATA_BUS_W-1:0] wdata_q;
   logic [DATA_BUS_W-1:0] rdata;
   logic                  wait_done;
   logic                  misaligned;
   logic                  commit;
   logic                  wr_en;
   logic                  unused_addr;

`ifdef DATA_RAM_WAIT_EN
   logic [3:0] wait_cnt;
   assign wait_done = (wait_cnt == 4'd0);
`else
   localparam int unused_wait_cycles = WAIT_CYCLES;
   assign wait_done = 1'b1;
`endif

   assign unused_addr = ^{addr_i[DATA_ADDR_BUS_W-1:DEPTH_LOG2+2]};
   assign misaligned  = is_misaligned(off_q, sel_q);
   assign commit      = (state == ST_BUSY) && ce_i && wait_done;
   assign wr_en       = rst && commit && we_q && !misaligned && (sel_q != SEL_NONE);
   assign dbg_state   = state;

   data_ram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk   (clk),
      .we    (wr_en),
      .be    (sel_q),
      .waddr (idx_q),
      .wdata (lane_data(sel_q, wdata_q)),
      .raddr (idx_q),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         ack_o  <= 1'b0;
         err_o  <= 1'b0;
         busy_o <= 1'b0;
         data_o <= '0;
`ifdef DATA_RAM_WAIT_EN
         wait_cnt <= 4'd0;
`endif
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ce_i) begin
                  we_q    <= we_i;
                  idx_q   <= addr_i[DEPTH_LOG2+1:2];
                  off_q   <= addr_i[1:0];
                  sel_q   <= sel_i;
                  wdata_q <= data_i;
                  busy_o  <= 1'b1;
                  state   <= ST_BUSY;
`ifdef DATA_RAM_WAIT_EN
                  wait_cnt <= 4'(WAIT_CYCLES);
`endif
               end
            end
            ST_BUSY: begin
               if (!ce_i) begin
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end else if (wait_done) begin
                  ack_o <= 1'b1;
                  err_o <= misaligned;
                  if (!we_q && !misaligned) data_o <= rdata & lane_mask(sel_q);
                  state <= ST_RESP;
               end
`ifdef DATA_RAM_WAIT_EN
               else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
`endif
            end
            ST_RESP: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
